// File: rtl/cache_pkg.sv
// Shared cache-subsystem definitions: widths, block geometry, arbiter state
// encoding and the block-base alignment helper used by caches and memory.
package cache_pkg;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int WORDS    = 8;
  localparam int MEM_LAT  = 4;
  localparam int OFF_W    = $clog2(WORDS);
  localparam int CNT_W    = OFF_W + 1;
  localparam int BLK_BITS = $clog2(WORDS * DATA_W / 8);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FILL_I = 2'd2,
    FILL_D = 2'd3
  } arb_state_e;

  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:BLK_BITS], {BLK_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Request, memory and cache-fill signals of the fill arbiter.
// master = arbiter side, slave = caches plus main memory.
interface cache_fill_arbiter_if;
  import cache_pkg::*;

  logic              i_miss;
  logic [ADDR_W-1:0] i_miss_addr;
  logic              d_miss;
  logic [ADDR_W-1:0] d_miss_addr;
  logic              d_write;
  logic [ADDR_W-1:0] d_write_addr;
  logic [DATA_W-1:0] d_write_data;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_data_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] fill_data;
  logic [OFF_W-1:0]  fill_word;
  logic              fill_i_we;
  logic              fill_d_we;
  logic              tag_i_we;
  logic              tag_d_we;
  logic              i_done;
  logic              d_done;
  logic              d_write_ack;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr,
    input  d_write, d_write_addr, d_write_data,
    input  mem_data_valid, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output fill_data, fill_word, fill_i_we, fill_d_we,
    output tag_i_we, tag_d_we, i_done, d_done, d_write_ack
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr,
    output d_write, d_write_addr, d_write_data,
    output mem_data_valid, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  fill_data, fill_word, fill_i_we, fill_d_we,
    input  tag_i_we, tag_d_we, i_done, d_done, d_write_ack
  );

endinterface

// File: rtl/fill_word_counter.sv
// Word counter for block fills: clear beats increment, and it saturates at
// WORDS so a stray extra pulse can never wrap it back into the block.
module fill_word_counter
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // next count
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {CNT_W{1'b0}};
    end else if (inc && !count_q[CNT_W-1]) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CNT_W'(WORDS - 1));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Grants the shared pipelined main memory to the I- or D-cache: 8-word block
// fills with tag write on the last word, and single-word write-through stores.
module cache_fill_arbiter
  import cache_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  cache_fill_arbiter_if.master bus
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ack_q, ack_d;

  logic [CNT_W-1:0]  iss_cnt, ret_cnt;
  logic              iss_last, ret_last;
  logic              filling, ret_ok, fill_end;

  // Returns are only accepted while filling; anything else on mem_data_valid is noise.
  assign filling  = (state_q == FILL_I) || (state_q == FILL_D);
  assign ret_ok   = filling && bus.mem_data_valid && !ret_cnt[CNT_W-1];
  assign fill_end = ret_ok && ret_last;

  fill_word_counter u_iss (
    .clk   (clk),
    .rst   (rst),
    .clr   (fill_end),
    .inc   (filling && mem_en_q),
    .count (iss_cnt),
    .last  (iss_last)
  );

  fill_word_counter u_ret (
    .clk   (clk),
    .rst   (rst),
    .clr   (fill_end),
    .inc   (ret_ok),
    .count (ret_cnt),
    .last  (ret_last)
  );

  // next state and next-cycle memory command
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = {ADDR_W{1'b0}};
    mem_wdata_d = {DATA_W{1'b0}};
    ack_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.d_miss) begin
          state_d    = FILL_D;
          base_d     = block_base(bus.d_miss_addr);
          mem_en_d   = 1'b1;
          mem_addr_d = block_base(bus.d_miss_addr);
        end else if (bus.d_write) begin
          state_d     = WRITE;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = bus.d_write_addr;
          mem_wdata_d = bus.d_write_data;
          ack_d       = 1'b1;
        end else if (bus.i_miss) begin
          state_d    = FILL_I;
          base_d     = block_base(bus.i_miss_addr);
          mem_en_d   = 1'b1;
          mem_addr_d = block_base(bus.i_miss_addr);
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      FILL_I, FILL_D: begin
        // The read issued this cycle is word iss_cnt; queue up the following one.
        if (fill_end) begin
          state_d = IDLE;
        end else if (mem_en_q && !iss_last && !iss_cnt[CNT_W-1]) begin
          mem_en_d   = 1'b1;
          mem_addr_d = base_q | ADDR_W'({iss_cnt[OFF_W-1:0] + OFF_W'(1), 1'b0});
        end else begin
          mem_en_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state, latched base and registered memory command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= {ADDR_W{1'b0}};
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
    end
  end

  assign bus.mem_en      = mem_en_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.d_write_ack = ack_q;

  // Fill writes follow the returning data in the same cycle.
  assign bus.fill_data = ret_ok ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.fill_word = ret_ok ? ret_cnt[OFF_W-1:0] : {OFF_W{1'b0}};
  assign bus.fill_i_we = ret_ok && (state_q == FILL_I);
  assign bus.fill_d_we = ret_ok && (state_q == FILL_D);
  assign bus.tag_i_we  = fill_end && (state_q == FILL_I);
  assign bus.tag_d_we  = fill_end && (state_q == FILL_D);
  assign bus.i_done    = fill_end && (state_q == FILL_I);
  assign bus.d_done    = fill_end && (state_q == FILL_D);

endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Shares the single 4-cycle-latency pipelined main memory between the I-cache and D-cache controllers inside the cache interface. It grants one requester at a time, sequences 8-word block fills (issue 8 reads back-to-back, collect 8 returns), and performs single-word write-through stores. It drives word-by-word fill writes plus a final tag/valid write into the granted cache, and signals completion so the pipeline stall can drop.

## Interface
Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- WORDS, 8, words per cache block (power of 2; 16-byte block)
- MEM_LAT, 4, cycles from read issue to `mem_data_valid`

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- i_miss  in  1  I-cache miss request, held until `i_done`
- i_miss_addr  in  ADDR_W  I-fetch miss address
- d_miss  in  1  D-cache miss request, held until `d_done`
- d_miss_addr  in  ADDR_W  data miss address
- d_write  in  1  write-through store request, held until `d_write_ack`
- d_write_addr  in  ADDR_W  store address
- d_write_data  in  DATA_W  store data
- mem_en  out  1  memory access issue this cycle
- mem_wr  out  1  issued access is a write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_data_valid  in  1  read data returning this cycle
- mem_rdata  in  DATA_W  returned read data
- fill_data  out  DATA_W  word to write into cache data array
- fill_word  out  log2(WORDS)  word offset within block
- fill_i_we / fill_d_we  out  1  data-array write enable, I / D cache
- tag_i_we / tag_d_we  out  1  tag+valid write enable, I / D cache
- i_done / d_done / d_write_ack  out  1  one-cycle completion pulses

## Operation
- States: IDLE, WRITE, FILL_I, FILL_D.
- IDLE grant priority: d_miss > d_write > i_miss. d_miss and d_write together is a protocol violation; d_miss wins.
- Grant is evaluated in IDLE only and is non-preemptive. A D request arriving during FILL_I waits for `i_done`.
- On grant, latch the block base `{addr[ADDR_W-1:4], 4'b0}` (fills), or the address and data (writes).
- WRITE, one cycle: mem_en=1, mem_wr=1, mem_addr/mem_wdata = latched values, d_write_ack=1, then IDLE.
- FILL_x: the issue counter `iss` runs 0..WORDS-1. Each cycle with iss<WORDS: mem_en=1, mem_wr=0, mem_addr = base + 2·iss.
  - Return counter `ret` advances on each mem_data_valid.
  - On each valid: fill_data=mem_rdata, fill_word=ret, fill_x_we=1.
  - On the valid with ret==WORDS-1, also assert tag_x_we=1 and x_done=1. Next state is IDLE and both counters clear.
- mem_data_valid outside FILL_x is ignored; it drives no fill_*_we.
- Address arithmetic wraps modulo 2^ADDR_W. The base is block-aligned, so no carry out of the block.
- All outputs are 0 in IDLE without a grant.
- Reset, including mid-fill: state=IDLE, iss=ret=0, latched registers=0, all outputs 0 on the next edge. A partially filled block gets no tag write, so it stays invalid.

## Timing
- Request sampled in IDLE at edge t → state entered at t+1.
- Write: ack and memory write in cycle t+1. Next grant is possible at t+2.
- Fill: reads issued in cycles t+1..t+8. Returns arrive in t+1+MEM_LAT .. t+8+MEM_LAT (t+5..t+12). Last fill write, tag write and done pulse all occur in t+12. IDLE in t+13.
- Fill latency from request to done is 12 cycles. Back-to-back fills have a 1-cycle IDLE gap.
- `mem_en` is never asserted by more than one requester in the same cycle. No write is issued while a fill's reads are outstanding.

## Structure
- Shared package `cache_pkg`: state enum (IDLE, WRITE, FILL_I, FILL_D), WORDS, MEM_LAT, block-offset width, and the block-base alignment function. These are shared with the cache and memory modules.
- One sub-module, `fill_word_counter`: a log2(WORDS)+1-bit counter with clear/increment/terminal flag, instantiated twice (issue and return).

## Test plan
- I-miss only, i_miss_addr=0x1236 → reads 0x1230..0x123E in 8 consecutive cycles; fill_i_we ×8 with fill_word 0..7; tag_i_we and i_done together exactly 12 cycles after the request.
- d_miss=0x8000 and i_miss=0x0040 in the same cycle → D fill completes first (d_done); I fill issues 0x0040 one cycle after the IDLE gap; i_done follows 13 cycles after d_done.
- d_write addr=0x2002, data=0xBEEF during FILL_I → no write issued until after i_done; then one cycle with mem_en=mem_wr=1, mem_addr=0x2002, mem_wdata=0xBEEF, d_write_ack=1.
- rst asserted during the 5th fill return → all outputs 0 next cycle; no tag write; a fresh i_miss afterwards restarts from word 0.
- Spurious mem_data_valid in IDLE → no fill/tag enables.
- Block at top of address space, miss_addr=0xFFFE → addresses 0xFFF0..0xFFFE, no wrap beyond.
